// File: rtl/pwm_multi_pkg.sv
// Shared constants for the multi-channel PWM block.
//  PWM_MODE_*  : counting mode encodings for center_mode
//  dir_e       : up/down direction of the centre-aligned counter
//  *_DEF       : default parameter values used by the top and interface
package pwm_multi_pkg;

  localparam logic PWM_MODE_EDGE   = 1'b0;
  localparam logic PWM_MODE_CENTER = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int unsigned CHANNELS_DEF   = 4;
  localparam int unsigned WIDTH_DEF      = 8;
  localparam int unsigned PRESCALE_W_DEF = 8;

endpackage

// File: rtl/pwm_multi_if.sv
// Register-side bundle of the multi-channel PWM block.
//  master : register interface (drives config, observes status/outputs)
//  slave  : pwm_multi (consumes config, drives pwm_out/period_tick/update_pend)
interface pwm_multi_if #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 8
);

  logic                      enable;
  logic [PRESCALE_W-1:0]     prescale;
  logic [WIDTH-1:0]          period;
  logic                      center_mode;
  logic [CHANNELS*WIDTH-1:0] level;
  logic [CHANNELS-1:0]       invert;
  logic                      update_req;

  logic [CHANNELS-1:0]       pwm_out;
  logic                      period_tick;
  logic                      update_pend;

  modport master (
    output enable, prescale, period, center_mode, level, invert, update_req,
    input  pwm_out, period_tick, update_pend
  );

  modport slave (
    input  enable, prescale, period, center_mode, level, invert, update_req,
    output pwm_out, period_tick, update_pend
  );

endinterface

// File: rtl/pwm_multi_timebase.sv
// Shared timebase: prescaler, period counter and direction, boundary detect.
//  clk, reset   : clock, synchronous active-high reset
//  enable       : 0 holds prescaler, counter and direction
//  prescale     : tick every prescale+1 clocks
//  period_sh    : shadowed counter top value
//  mode_sh      : shadowed counting mode (edge / centre)
//  count        : registered counter value
//  boundary_c   : combinational, high in the cycle that ends a period
module pwm_multi_timebase
  import pwm_multi_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      period_sh,
  input  logic                  mode_sh,
  output logic [WIDTH-1:0]      count,
  output logic                  boundary_c
);

  logic [PRESCALE_W-1:0] psc_cnt;
  logic [PRESCALE_W-1:0] psc_nxt;
  logic [WIDTH-1:0]      count_nxt;
  dir_e                  dir;
  dir_e                  dir_nxt;
  logic                  tick_c;

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      psc_cnt <= '0;
      count   <= '0;
      dir     <= DIR_UP;
    end else begin
      psc_cnt <= psc_nxt;
      count   <= count_nxt;
      dir     <= dir_nxt;
    end
  end

  // Next-state: prescaler tick, then counter step / reversal / boundary
  always_comb begin
    psc_nxt    = psc_cnt;
    count_nxt  = count;
    dir_nxt    = dir;
    tick_c     = 1'b0;
    boundary_c = 1'b0;

    // >= so a prescale lowered below the running count still ticks and wraps
    if (enable) begin
      if (psc_cnt >= prescale) begin
        tick_c  = 1'b1;
        psc_nxt = '0;
      end else begin
        psc_nxt = psc_cnt + PRESCALE_W'(1);
      end
    end

    if (tick_c) begin
      if (mode_sh == PWM_MODE_EDGE) begin
        if (count >= period_sh) begin
          boundary_c = 1'b1;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end else begin
        if (period_sh == '0) begin
          boundary_c = 1'b1;
        end else if (dir == DIR_DOWN) begin
          // last down-step (1 -> 0) closes the period
          if (count <= WIDTH'(1)) begin
            boundary_c = 1'b1;
          end else begin
            count_nxt = count - WIDTH'(1);
          end
        end else begin
          if (count >= period_sh) begin
            dir_nxt   = DIR_DOWN;
            count_nxt = count - WIDTH'(1);
          end else begin
            count_nxt = count + WIDTH'(1);
            if (count_nxt == period_sh) begin
              dir_nxt = DIR_DOWN;
            end
          end
        end
      end

      // every period restarts counting up from zero
      if (boundary_c) begin
        count_nxt = '0;
        dir_nxt   = DIR_UP;
      end
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared timebase, shadowed config, per-channel compare.
//  clk, reset : clock, synchronous active-high reset
//  bus        : pwm_multi_if.slave
//               in : enable, prescale, period, center_mode, level, invert, update_req
//               out: pwm_out (registered), period_tick (1-clk pulse), update_pend
module pwm_multi
  import pwm_multi_pkg::*;
#(
  parameter int unsigned CHANNELS   = CHANNELS_DEF,
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic      clk,
  input  logic      reset,
  pwm_multi_if.slave bus
);

  logic [WIDTH-1:0]    period_sh;
  logic                mode_sh;
  logic [WIDTH-1:0]    level_sh [CHANNELS];
  logic [WIDTH-1:0]    count;
  logic                boundary_c;
  logic                load_c;
  logic [CHANNELS-1:0] cmp_c;
  logic [CHANNELS-1:0] pwm_q;
  logic                tick_q;
  logic                pend_q;

  pwm_multi_timebase #(
    .WIDTH      (WIDTH),
    .PRESCALE_W (PRESCALE_W)
  ) u_timebase (
    .clk        (clk),
    .reset      (reset),
    .enable     (bus.enable),
    .prescale   (bus.prescale),
    .period_sh  (period_sh),
    .mode_sh    (mode_sh),
    .count      (count),
    .boundary_c (boundary_c)
  );

  // Shadows follow live config during reset and at an update boundary
  assign load_c = reset | (boundary_c & (pend_q | bus.update_req));

  always_ff @(posedge clk) begin
    if (load_c) begin
      period_sh <= bus.period;
      mode_sh   <= bus.center_mode;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        level_sh[i] <= bus.level[i*WIDTH +: WIDTH];
      end
    end
  end

  // Update handshake and period pulse; a boundary always consumes a pending update
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= boundary_c;
      if (boundary_c) begin
        pend_q <= 1'b0;
      end else if (bus.update_req) begin
        pend_q <= 1'b1;
      end
    end
  end

  // Per-channel compare; polarity taken live so it is never delayed by the shadow
  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
    assign cmp_c[g] = (count < level_sh[g]) ^ bus.invert[g];
  end

  // Output flops: idle level is the channel polarity while disabled
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_q <= '0;
    end else if (!bus.enable) begin
      pwm_q <= bus.invert;
    end else begin
      pwm_q <= cmp_c;
    end
  end

  assign bus.pwm_out     = pwm_q;
  assign bus.period_tick = tick_q;
  assign bus.update_pend = pend_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: table of config vectors measured over one
// full period each, plus directed sequences for shadowing, coincident update,
// enable hold/resume and mid-period reset.
module tb_pwm_multi;

  localparam int unsigned CH = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned PW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pwm_multi_if #(.CHANNELS(CH), .WIDTH(W), .PRESCALE_W(PW)) bus ();

  pwm_multi #(.CHANNELS(CH), .WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [PW-1:0]          psc;
    logic [W-1:0]           per;
    logic                   ctr;
    logic [CH*W-1:0]        lvl;
    logic [CH-1:0]          inv;
    logic [CH-1:0][15:0]    hi;
    logic [15:0]            len;
  } vec_t;

  typedef struct packed {
    logic [CH-1:0][15:0]    hi;
    logic [15:0]            len;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[5];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic [PW-1:0] psc, input logic [W-1:0] per,
                              input logic ctr, input logic [CH*W-1:0] lvl,
                              input logic [CH-1:0] inv, input logic [CH-1:0][15:0] hi,
                              input logic [15:0] len);
    vec_t v;
    v.psc = psc; v.per = per; v.ctr = ctr; v.lvl = lvl;
    v.inv = inv; v.hi = hi; v.len = len;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_update();
    bus.update_req = 1'b1;
    step();
    bus.update_req = 1'b0;
  endtask

  task automatic push_exp(input logic [CH-1:0][15:0] hi, input logic [15:0] len);
    exp_t e;
    e.hi  = hi;
    e.len = len;
    sb.push_back(e);
  endtask

  // Returns with the bench sitting on a period_tick cycle (or after the bound)
  task automatic wait_tick(input string name, input int limit);
    int n;
    n = 0;
    while (!bus.period_tick && n < limit) begin
      step();
      n++;
    end
    check({name, "_tick_seen"}, int'(bus.period_tick), 1);
  endtask

  // Starting on a tick cycle: count highs over exactly one period and compare
  task automatic measure(input string name);
    int   hi [CH];
    int   len;
    exp_t e;
    for (int c = 0; c < int'(CH); c++) hi[c] = 0;
    len = 0;
    for (int n = 0; n < 600; n++) begin
      step();
      len++;
      for (int c = 0; c < int'(CH); c++) if (bus.pwm_out[c]) hi[c]++;
      if (bus.period_tick) break;
    end
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      for (int c = 0; c < int'(CH); c++)
        check($sformatf("%s_ch%0d_hi", name, c), hi[c], int'(e.hi[c]));
      check({name, "_len"}, len, int'(e.len));
    end
  endtask

  // Clock steps from now until the next period_tick
  task automatic steps_to_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.period_tick && n < 200);
  endtask

  initial begin
    int  n;
    bit  ok;
    int  runt;

    vecs[0] = mk(8'd0, 8'd9, 1'b0, {8'd5, 8'd10, 8'd0, 8'd3}, 4'b0000,
                 {16'd5, 16'd10, 16'd0, 16'd3}, 16'd10);
    vecs[1] = mk(8'd1, 8'd4, 1'b1, {8'd4, 8'd5, 8'd0, 8'd2}, 4'b0000,
                 {16'd14, 16'd16, 16'd0, 16'd6}, 16'd16);
    vecs[2] = mk(8'd2, 8'd3, 1'b0, {8'd0, 8'd3, 8'd4, 8'd1}, 4'b0101,
                 {16'd0, 16'd3, 16'd12, 16'd9}, 16'd12);
    vecs[3] = mk(8'd0, 8'd0, 1'b0, {8'd0, 8'd255, 8'd1, 8'd0}, 4'b0000,
                 {16'd0, 16'd1, 16'd1, 16'd0}, 16'd1);
    vecs[4] = mk(8'd0, 8'd1, 1'b1, {8'd1, 8'd0, 8'd2, 8'd1}, 4'b0000,
                 {16'd1, 16'd0, 16'd2, 16'd1}, 16'd2);

    // Reset with edge period 9 live; polarity must be ignored during reset
    reset           = 1'b1;
    bus.enable      = 1'b1;
    bus.prescale    = 8'd0;
    bus.period      = 8'd9;
    bus.center_mode = 1'b0;
    bus.level       = {8'd5, 8'd10, 8'd0, 8'd3};
    bus.invert      = 4'b1010;
    bus.update_req  = 1'b0;
    repeat (3) step();
    check("rst_pwm_out", int'(bus.pwm_out), 0);
    check("rst_period_tick", int'(bus.period_tick), 0);
    check("rst_update_pend", int'(bus.update_pend), 0);
    bus.invert = 4'b0000;
    reset      = 1'b0;
    steps_to_tick(n);
    check("first_period_len", n, 10);

    // Table-driven config vectors
    for (int i = 0; i < 5; i++) begin
      push_exp(vecs[i].hi, vecs[i].len);
      bus.prescale    = vecs[i].psc;
      bus.period      = vecs[i].per;
      bus.center_mode = vecs[i].ctr;
      bus.level       = vecs[i].lvl;
      bus.invert      = vecs[i].inv;
      pulse_update();
      wait_tick($sformatf("vec%0d", i), 100);
      check($sformatf("vec%0d_pend_clr", i), int'(bus.update_pend), 0);
      measure($sformatf("vec%0d", i));
    end

    // Shadowing: live level change alone has no effect
    bus.prescale    = 8'd0;
    bus.period      = 8'd9;
    bus.center_mode = 1'b0;
    bus.level       = {8'd0, 8'd0, 8'd0, 8'd3};
    bus.invert      = 4'b0000;
    pulse_update();
    wait_tick("shadow_setup", 100);
    bus.level = {8'd0, 8'd0, 8'd0, 8'd7};
    push_exp({16'd0, 16'd0, 16'd0, 16'd3}, 16'd10);
    measure("shadow_hold");
    // Mid-period request: pending until boundary, no runt of the new duty
    repeat (3) step();
    pulse_update();
    check("shadow_pend_set", int'(bus.update_pend), 1);
    ok = 1'b1;
    runt = 0;
    n = 0;
    while (!bus.period_tick && n < 50) begin
      if (!bus.update_pend) ok = 1'b0;
      if (bus.pwm_out[0]) runt++;
      step();
      n++;
    end
    if (bus.pwm_out[0]) runt++;
    check("shadow_pend_held", int'(ok), 1);
    check("shadow_no_runt", runt, 0);
    check("shadow_tick_seen", int'(bus.period_tick), 1);
    check("shadow_pend_clr", int'(bus.update_pend), 0);
    push_exp({16'd0, 16'd0, 16'd0, 16'd7}, 16'd10);
    measure("shadow_new");

    // Coincident request in the boundary cycle (count==9)
    repeat (9) step();
    bus.level = {8'd0, 8'd0, 8'd0, 8'd2};
    pulse_update();
    check("coinc_tick", int'(bus.period_tick), 1);
    check("coinc_pend", int'(bus.update_pend), 0);
    push_exp({16'd0, 16'd0, 16'd0, 16'd2}, 16'd10);
    measure("coinc");

    // Enable hold: idle at polarity, counter resumes from held value (4)
    bus.invert = 4'b0101;
    repeat (4) step();
    bus.enable = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus.pwm_out != 4'b0101 || bus.period_tick) ok = 1'b0;
    end
    check("dis_idle_level", int'(ok), 1);
    check("dis_pwm_out", int'(bus.pwm_out), 5);
    bus.enable = 1'b1;
    steps_to_tick(n);
    check("resume_steps_to_tick", n, 6);
    push_exp({16'd0, 16'd10, 16'd0, 16'd8}, 16'd10);
    measure("resume");

    // Reset mid-period with a pending update and a simultaneous request
    bus.level  = {8'd0, 8'd0, 8'd0, 8'd4};
    bus.period = 8'd5;
    repeat (3) step();
    pulse_update();
    check("rst2_pend_before", int'(bus.update_pend), 1);
    repeat (2) step();
    reset          = 1'b1;
    bus.update_req = 1'b1;
    step();
    bus.update_req = 1'b0;
    step();
    check("rst2_pwm_out", int'(bus.pwm_out), 0);
    check("rst2_update_pend", int'(bus.update_pend), 0);
    check("rst2_period_tick", int'(bus.period_tick), 0);
    reset = 1'b0;
    steps_to_tick(n);
    check("rst2_first_len", n, 6);
    push_exp({16'd0, 16'd6, 16'd0, 16'd2}, 16'd6);
    measure("rst2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
